// File: rtl/builtin_type_unpacker_pkg.sv
// Shared types for the builtin integer unpacker: the type code layout, the FSM
// states and the mapping from size code to byte count.
package builtin_type_unpacker_pkg;

    localparam logic [1:0] SZ_BYTE     = 2'd0;
    localparam logic [1:0] SZ_SHORTINT = 2'd1;
    localparam logic [1:0] SZ_INT      = 2'd2;
    localparam logic [1:0] SZ_LONGINT  = 2'd3;

    typedef struct packed {
        logic       is_signed;
        logic [1:0] size;
    } kind_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE:     return 4'd1;
            SZ_SHORTINT: return 4'd2;
            SZ_INT:      return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/builtin_type_extend.sv
// Zero/sign extension of an n-byte integer held in the low bytes of a 64-bit
// word. Purely combinational so a packer can share it.
module builtin_type_extend
    import builtin_type_unpacker_pkg::*;
(
    input  logic [63:0] raw_i,
    input  kind_t       kind_i,
    output logic [63:0] value_o
);

    // Bytes above the active width may hold stale data; they are always replaced.
    always_comb begin
        value_o = raw_i;
        case (kind_i.size)
            SZ_BYTE:     value_o = {{56{kind_i.is_signed & raw_i[7]}},  raw_i[7:0]};
            SZ_SHORTINT: value_o = {{48{kind_i.is_signed & raw_i[15]}}, raw_i[15:0]};
            SZ_INT:      value_o = {{32{kind_i.is_signed & raw_i[31]}}, raw_i[31:0]};
            default:     value_o = raw_i;
        endcase
    end

endmodule

// File: rtl/builtin_type_unpacker.sv
// Rebuilds byte/shortint/int/longint values from a byte stream and presents them
// extended to 64 bits. Define BUILTIN_TYPE_UNPACKER_COUNT_EN to add o_count.
module builtin_type_unpacker
    import builtin_type_unpacker_pkg::*;
#(
    parameter bit LITTLE_ENDIAN = 1'b1
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    input  logic [7:0]  i_byte,
    input  logic [2:0]  i_kind,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_value,
    output logic [2:0]  o_kind
`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
    ,
    output logic [15:0] o_count
`endif
);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d, cur_kind;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  n_bytes;
    logic [2:0]  lane_sel;
    logic [7:0]  lane_we;
    logic [63:0] raw_q;
    logic        rdy_q;
    logic        byte_xfer;
    logic        value_xfer;

    // rdy_q keeps o_byte_ready low until the first edge after reset release.
    assign o_byte_ready = rdy_q && (state_q != HOLD);
    assign o_valid      = (state_q == HOLD);
    assign o_kind       = kind_q;
    assign byte_xfer    = i_byte_valid && o_byte_ready;
    assign value_xfer   = o_valid && i_ready;

    // The first byte of a value is sized from the live i_kind, later ones from the latched kind.
    always_comb begin
        cur_kind = (state_q == IDLE) ? kind_t'(i_kind) : kind_q;
        n_bytes  = size_bytes(cur_kind.size);
        lane_sel = LITTLE_ENDIAN ? byte_idx_q[2:0] : 3'(n_bytes - 4'd1 - byte_idx_q);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane_we
            assign lane_we[gi] = byte_xfer && (lane_sel == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: begin
                if (byte_xfer) begin
                    kind_d     = kind_t'(i_kind);
                    byte_idx_d = 4'd1;
                    state_d    = (n_bytes == 4'd1) ? HOLD : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_xfer) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (byte_idx_q == n_bytes - 4'd1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (value_xfer) begin
                    state_d    = IDLE;
                    byte_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            kind_q     <= '0;
            byte_idx_q <= '0;
            rdy_q      <= 1'b0;
            raw_q      <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            byte_idx_q <= byte_idx_d;
            rdy_q      <= 1'b1;
            for (int b = 0; b < 8; b++) begin
                if (lane_we[b]) begin
                    raw_q[8*b +: 8] <= i_byte;
                end
            end
        end
    end

    builtin_type_extend u_extend (
        .raw_i   (raw_q),
        .kind_i  (kind_q),
        .value_o (o_value)
    );

`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
    logic [15:0] value_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            value_cnt_q <= '0;
        end else if (value_xfer && (value_cnt_q != 16'hFFFF)) begin
            value_cnt_q <= value_cnt_q + 16'd1;
        end
    end

    assign o_count = value_cnt_q;
`endif

endmodule

// File: tb/tb_builtin_type_unpacker.sv
// Bench for builtin_type_unpacker: little- and big-endian instances share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_builtin_type_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic [2:0]  in_kind = '0;
    logic        ready = 1'b0;

    logic        byte_ready_le, byte_ready_be;
    logic        valid_le, valid_be;
    logic [63:0] value_le, value_be;
    logic [2:0]  kind_le, kind_be;
`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
    logic [15:0] count_le, count_be;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  d_kind [4] = '{3'b000, 3'b101, 3'b110, 3'b010};
    logic [63:0] d_bytes[4] = '{64'hF0, 64'h8234, 64'h01000080, 64'h01000080};
    logic [63:0] d_le   [4] = '{64'h00000000_000000F0, 64'hFFFFFFFF_FFFF8234,
                                64'h00000000_01000080, 64'h00000000_01000080};
    logic [63:0] d_be   [4] = '{64'h00000000_000000F0, 64'h00000000_00003482,
                                64'hFFFFFFFF_80000001, 64'h00000000_80000001};

    always #5 clk = ~clk;

    builtin_type_unpacker #(.LITTLE_ENDIAN(1'b1)) dut_le (
        .i_clk(clk), .i_rst(rst_n), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready_le),
        .i_byte(byte_data), .i_kind(in_kind), .o_valid(valid_le), .i_ready(ready),
        .o_value(value_le), .o_kind(kind_le)
`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
        , .o_count(count_le)
`endif
    );

    builtin_type_unpacker #(.LITTLE_ENDIAN(1'b0)) dut_be (
        .i_clk(clk), .i_rst(rst_n), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready_be),
        .i_byte(byte_data), .i_kind(in_kind), .o_valid(valid_be), .i_ready(ready),
        .o_value(value_be), .o_kind(kind_be)
`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
        , .o_count(count_be)
`endif
    );

    // Reference: place n bytes by weight, then extend from bit 8n-1.
    function automatic logic [63:0] ref_value(input logic [2:0] kind, input logic [63:0] b, input bit le);
        int n;
        int pos;
        logic [63:0] v;
        logic [63:0] mask;
        n = 1 << kind[1:0];
        v = '0;
        for (int k = 0; k < n; k++) begin
            pos = le ? k : (n - 1 - k);
            v = v | ({56'd0, b[8*k +: 8]} << (8 * pos));
        end
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            if (kind[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // gap_pct < 0 toggles byte_valid every cycle; otherwise that percentage of idle cycles.
    task automatic send_value(input logic [2:0] kind, input logic [63:0] b, input int gap_pct, output bit ok);
        int n;
        int k;
        int cyc;
        bit acc;
        n = 1 << kind[1:0];
        k = 0;
        cyc = 0;
        ok = 1'b1;
        @(posedge clk); #1;
        while (k < n) begin
            if (cyc > 400) begin
                ok = 1'b0;
                break;
            end
            if (gap_pct < 0) byte_valid = (cyc % 2 == 0);
            else             byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data = byte_valid ? b[8*k +: 8] : 8'($urandom);
            in_kind   = (k == 0) ? kind : 3'($urandom);
            @(negedge clk);
            acc = byte_valid && byte_ready_le;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (byte_ready_le !== 1'b0 || byte_ready_be !== 1'b0 || valid_le !== 1'b0 || valid_be !== 1'b0 ||
            value_le !== 64'd0 || value_be !== 64'd0 || kind_le !== 3'd0 || kind_be !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b/%b valid=%b/%b value=%h/%h kind=%0d/%0d required all zero",
                     byte_ready_le, byte_ready_be, valid_le, valid_be, value_le, value_be, kind_le, kind_be);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (byte_ready_le !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 0", byte_ready_le);
        end
        @(negedge clk);
        n_checks++;
        if (byte_ready_le !== 1'b1 || byte_ready_be !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b/%b required 1", byte_ready_le, byte_ready_be);
        end
        $display("reset: ready=%b valid=%b", byte_ready_le, valid_le);
    endtask

    task automatic test_directed();
        bit ok;
        for (int i = 0; i < 4; i++) begin
            send_value(d_kind[i], d_bytes[i], 0, ok);
            @(negedge clk);
            n_checks++;
            if (!ok || valid_le !== 1'b1 || valid_be !== 1'b1 || value_le !== d_le[i] || value_be !== d_be[i] ||
                kind_le !== d_kind[i] || kind_be !== d_kind[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: ok=%b valid=%b/%b value=%h/%h kind=%0d/%0d required value=%h/%h kind=%0d",
                         i, ok, valid_le, valid_be, value_le, value_be, kind_le, kind_be, d_le[i], d_be[i], d_kind[i]);
            end
            consume();
            @(negedge clk);
            n_checks++;
            if (valid_le !== 1'b0 || valid_be !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_release_%0d: valid=%b/%b required 0", i, valid_le, valid_be);
            end
            $display("directed %0d: kind=%b le=%h be=%h", i, d_kind[i], value_le, value_be);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] b;
        b = 64'h08070605_04030201;
        send_value(3'b011, b, -1, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || valid_le !== 1'b1 || value_le !== 64'h08070605_04030201 || value_be !== 64'h01020304_05060708) begin
            n_fail++;
            $display("FAIL longint_result: ok=%b valid=%b value=%h/%h required 0807060504030201/0102030405060708",
                     ok, valid_le, value_le, value_be);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (byte_ready_le !== 1'b0 || byte_ready_be !== 1'b0 || valid_le !== 1'b1 ||
                value_le !== 64'h08070605_04030201 || value_be !== 64'h01020304_05060708) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d: rdy=%b/%b valid=%b value=%h/%h required rdy=0 valid=1 value stable",
                         c, byte_ready_le, byte_ready_be, valid_le, value_le, value_be);
            end
        end
        byte_valid = 1'b0;
        consume();
        $display("backpressure: value=%h held 5 cycles", value_le);
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(posedge clk); #1;
        byte_valid = 1'b1;
        in_kind    = 3'b110;
        byte_data  = 8'h11;
        @(posedge clk); #1;
        byte_data  = 8'h22;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_le !== 1'b0 || byte_ready_le !== 1'b0 || valid_be !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b/%b rdy=%b required 0", valid_le, valid_be, byte_ready_le);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid_le !== 1'b0 || valid_be !== 1'b0) begin
            n_fail++;
            $display("FAIL no_partial_valid: valid=%b/%b required 0", valid_le, valid_be);
        end
        send_value(3'b100, 64'hFF, 0, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || valid_le !== 1'b1 || value_le !== 64'hFFFFFFFF_FFFFFFFF || value_be !== 64'hFFFFFFFF_FFFFFFFF ||
            kind_le !== 3'b100) begin
            n_fail++;
            $display("FAIL after_mid_reset: ok=%b valid=%b value=%h/%h kind=%0d required all ones kind 4",
                     ok, valid_le, value_le, value_be, kind_le);
        end
        consume();
        $display("reset_mid: value=%h", value_le);
    endtask

    task automatic test_random();
        bit ok;
        logic [2:0]  kind;
        logic [63:0] b, exp_le, exp_be;
        int hold;
        for (int i = 0; i < 30; i++) begin
            kind   = 3'($urandom_range(7));
            b      = {$urandom, $urandom};
            hold   = $urandom_range(3);
            exp_le = ref_value(kind, b, 1'b1);
            exp_be = ref_value(kind, b, 1'b0);
            send_value(kind, b, $urandom_range(60), ok);
            repeat (hold) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (!ok || valid_le !== 1'b1 || valid_be !== 1'b1 || value_le !== exp_le || value_be !== exp_be ||
                kind_le !== kind || kind_be !== kind || byte_ready_le !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d: ok=%b valid=%b/%b value=%h/%h kind=%0d required %h/%h kind=%0d",
                         i, ok, valid_le, valid_be, value_le, value_be, kind_le, exp_le, exp_be, kind);
            end
            consume();
            $display("random %0d: kind=%b bytes=%h le=%h be=%h", i, kind, b, value_le, value_be);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [2:0]  kind;
        logic [63:0] b, exp_le, exp_be;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            kind   = 3'($urandom_range(7));
            b      = {$urandom, $urandom};
            exp_le = ref_value(kind, b, 1'b1);
            exp_be = ref_value(kind, b, 1'b0);
            send_value(kind, b, 0, ok);
            @(negedge clk);
            n_checks++;
            if (!ok || valid_le !== 1'b1 || byte_ready_le !== 1'b0 || value_le !== exp_le || value_be !== exp_be) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: ok=%b valid=%b rdy=%b value=%h/%h required valid=1 rdy=0 %h/%h",
                         i, ok, valid_le, byte_ready_le, value_le, value_be, exp_le, exp_be);
            end
            $display("back_to_back %0d: kind=%b le=%h", i, kind, value_le);
        end
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_le !== 1'b0 || byte_ready_le !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_drain: valid=%b rdy=%b required 0/1", valid_le, byte_ready_le);
        end
    endtask

`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
    task automatic test_count();
        bit ok;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_value(3'($urandom_range(7)), {$urandom, $urandom}, 0, ok);
            consume();
        end
        @(negedge clk);
        n_checks++;
        if (count_le !== 16'd3 || count_be !== 16'd3) begin
            n_fail++;
            $display("FAIL count_three: got %0d/%0d required 3", count_le, count_be);
        end
        dut_le.value_cnt_q = 16'hFFFF;
        dut_be.value_cnt_q = 16'hFFFF;
        send_value(3'b000, 64'h5A, 0, ok);
        consume();
        @(negedge clk);
        n_checks++;
        if (count_le !== 16'hFFFF || count_be !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL count_saturate: got %h/%h required ffff", count_le, count_be);
        end
        $display("count: %0d", count_le);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef BUILTIN_TYPE_UNPACKER_COUNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/builtin_type_unpacker.md
Name: builtin_type_unpacker

Overview:
- Receiver side for builtin integer types: rebuilds byte, shortint, int and longint values (signed or unsigned) from an 8-bit byte stream.
- Each value is zero- or sign-extended to 64 bits and presented on a valid/ready output.
- Sits between a byte-serial link and logic that consumes typed integers.

Parameters:
- LITTLE_ENDIAN, 1, 1: first byte received is the least significant; 0: first byte is the most significant of the n-byte value.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_byte_valid  input  1  byte stream valid
- o_byte_ready  output  1  byte stream ready
- i_byte  input  8  byte data
- i_kind  input  3  type code, sampled only with the first byte of a value; [1:0]: 0 byte (1B), 1 shortint (2B), 2 int (4B), 3 longint (8B); [2]: 1 signed, 0 unsigned
- o_valid  output  1  assembled value valid
- i_ready  input  1  consumer ready
- o_value  output  64  extended value
- o_kind  output  3  type code of o_value

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-low.
- Reset values: o_byte_ready=0 while reset is asserted and 1 from the first clock edge after release. o_valid=0, o_value=0, o_kind=0; internal byte count 0; state IDLE.
- Handshakes: a byte transfers when i_byte_valid and o_byte_ready are both 1 at the clock edge. A value transfers when o_valid and i_ready are both 1.
- State IDLE:
  - o_byte_ready=1, o_valid=0.
  - On a byte transfer: latch i_kind; set n = 1/2/4/8 from i_kind[1:0]; store the byte at index 0; count=1.
  - If n==1 go to HOLD, else go to COLLECT.
- State COLLECT:
  - o_byte_ready=1.
  - Each byte transfer stores the byte at index count, then count+1.
  - When the stored index equals n-1, go to HOLD.
  - i_kind is ignored while in COLLECT.
- Byte placement:
  - LITTLE_ENDIAN=1: byte at index k goes to bits [8k+7:8k].
  - LITTLE_ENDIAN=0: byte at index k goes to bits [8(n-1-k)+7:8(n-1-k)].
- State HOLD:
  - o_byte_ready=0, o_valid=1.
  - o_value and o_kind stay stable until the value transfers; on transfer go to IDLE and clear count.
- Extension: bits [63:8n] are copies of bit 8n-1 when signed, otherwise 0. Computed from registered bytes, so it adds no extra cycle.
- Latency: o_valid rises on the clock edge that accepts the final byte, i.e. it is visible in the following cycle.
- Throughput: one byte per cycle inside a value. At least one cycle with o_byte_ready=0 (HOLD) between values. The byte source must tolerate this.
- Backpressure: if i_ready is held low, the block stays in HOLD indefinitely; no bytes are accepted and none are lost.
- Reset mid-operation: the partial value is discarded immediately. No o_valid is produced for it.
- i_byte_valid low during COLLECT: the block waits, with no timeout.

Optional Feature:
- Macro: BUILTIN_TYPE_UNPACKER_COUNT_EN.
- Defined:
  - Adds port o_count, output, 16 bits.
  - o_count resets to 0 and increments on each value transfer, saturating at 16'hFFFF.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package builtin_type_unpacker_pkg contains:
  - kind_t (3-bit packed struct: is_signed, size code)
  - size code constants SZ_BYTE=0, SZ_SHORTINT=1, SZ_INT=2, SZ_LONGINT=3
  - state_t enum {IDLE, COLLECT, HOLD}
  - a function mapping size code to byte count
- Sub-module builtin_type_extend (combinational): inputs are the 64-bit raw assembly and kind_t; output is the extended value. It can be reused by a future packer.

Test Plan:
- Unsigned byte, kind=3'b000, byte 8'hF0 -> one cycle later o_valid=1, o_value=64'h00000000_000000F0, o_kind=0.
- Signed shortint, LITTLE_ENDIAN=1, kind=3'b101, bytes 8'h34, 8'h82 -> o_value=64'hFFFFFFFF_FFFF8234.
- Signed int, LITTLE_ENDIAN=0, kind=3'b110, bytes 8'h80,8'h00,8'h00,8'h01 -> o_value=64'hFFFFFFFF_80000001; repeat with kind=3'b010 -> 64'h00000000_80000001.
- Unsigned longint, bytes 01..08 with i_byte_valid toggled every cycle and i_ready held low 5 cycles -> o_byte_ready=0 and o_value stable throughout; LE result 64'h08070605_04030201.
- Assert reset after 2 of 4 int bytes, release, send byte kind 3'b100 value 8'hFF -> o_value=64'hFFFFFFFF_FFFFFFFF, with no earlier o_valid.
- With BUILTIN_TYPE_UNPACKER_COUNT_EN defined, 3 values transferred -> o_count=3; after a preload to 16'hFFFF, one more transfer -> stays 16'hFFFF.
